// File: rtl/detection_ddr_writer.sv
// detection_ddr_writer: turns detection FIFO commands into 4KB-safe AXI4 INCR write bursts (optional DETECTION_DDR_WR_STATS_EN counters)
module detection_ddr_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST_BEATS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           cmd_dout,
  input  logic                  cmd_empty,
  output logic                  cmd_rd_en,
  input  logic [127:0]          dat_dout,
  input  logic                  dat_empty,
  output logic                  dat_rd_en,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [127:0]          m_axi_wdata,
  output logic [15:0]           m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
`ifdef DETECTION_DDR_WR_STATS_EN
  ,
  output logic [31:0]           stat_cmd_cnt,
  output logic [31:0]           stat_cycles_max,
  output logic [31:0]           stat_backpressure_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, AW, W, B, FIN} state_t;
  localparam logic [8:0] MAX_B = 9'(MAX_BURST_BEATS);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0] remaining, burst, room, burst_rb, burst_n;
  logic [7:0] beat_cnt;
  logic w_hs, b_done, unused_bits;
  assign unused_bits = ^{cmd_dout[63:ADDR_WIDTH+12], cmd_dout[3:0]};
  // beats left before the next 4KB boundary; addr is always beat-aligned
  assign room = 9'd256 - {1'b0, addr[11:4]};
  assign burst_rb = remaining < room ? remaining : room;
  assign burst_n = burst_rb < MAX_B ? burst_rb : MAX_B;
  assign cmd_rd_en = ~rst & (state == IDLE) & ~cmd_empty;
  assign m_axi_awvalid = ~rst & (state == AW);
  assign m_axi_wvalid = ~rst & (state == W) & ~dat_empty;
  assign m_axi_wdata = dat_dout;
  assign m_axi_wlast = ~rst & (state == W) & (beat_cnt == m_axi_awlen);
  assign w_hs = m_axi_wvalid & m_axi_wready;
  assign dat_rd_en = w_hs;
  assign m_axi_bready = ~rst & (state == B);
  assign b_done = (state == B) & m_axi_bvalid;
  assign busy = ~rst & (state != IDLE);
  assign done = ~rst & (state == FIN);
  assign m_axi_awsize = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb = 16'hFFFF;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = cmd_rd_en ? LOAD : IDLE;
      LOAD:    state_n = AW;
      AW:      state_n = m_axi_awready ? W : AW;
      W:       state_n = (w_hs && m_axi_wlast) ? B : W;
      B:       state_n = m_axi_bvalid ? (remaining != burst ? LOAD : FIN) : B;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      burst <= '0;
      beat_cnt <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen <= '0;
      err <= '0;
    end else begin
      state <= state_n;
      if (cmd_rd_en) begin
        addr <= {cmd_dout[ADDR_WIDTH+11:16], 4'b0};
        remaining <= {1'b0, cmd_dout[11:4]} + 9'd1;
      end
      if (state == LOAD) begin
        burst <= burst_n;
        m_axi_awaddr <= addr;
        m_axi_awlen <= 8'(burst_n - 9'd1);
        beat_cnt <= '0;
      end
      if (w_hs) beat_cnt <= beat_cnt + 8'd1;
      if (b_done) begin
        remaining <= remaining - burst;
        addr <= addr + ADDR_WIDTH'({burst, 4'b0});
      end
      // a new error in the same cycle as err_clr survives the clear
      err <= (err & ~{2{err_clr}}) | {cmd_rd_en & (|cmd_dout[15:12]), b_done & (|m_axi_bresp)};
    end
  end
`ifdef DETECTION_DDR_WR_STATS_EN
  logic [31:0] cyc, cyc_inc;
  assign cyc_inc = &cyc ? cyc : cyc + 32'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
      stat_cmd_cnt <= '0;
      stat_cycles_max <= '0;
      stat_backpressure_cnt <= '0;
    end else begin
      cyc <= (state == IDLE) ? '0 : cyc_inc;
      if (done && !(&stat_cmd_cnt)) stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
      if (done && cyc_inc > stat_cycles_max) stat_cycles_max <= cyc_inc;
      if (m_axi_wvalid && !m_axi_wready && !(&stat_backpressure_cnt))
        stat_backpressure_cnt <= stat_backpressure_cnt + 32'd1;
    end
  end
`endif
endmodule
